// File: rtl/evr_pulse_receiver_pkg.sv
// evr_pkg: event codes and channel state encoding shared by the EVR pulse receiver
package evr_pkg;
    localparam logic [7:0] EV_SHIFT0  = 8'h70;
    localparam logic [7:0] EV_SHIFT1  = 8'h71;
    localparam logic [7:0] EV_SECONDS = 8'h7D;
    typedef enum logic [1:0] {CH_IDLE, CH_DELAY, CH_ACTIVE} ch_state_e;
endpackage

// File: rtl/evr_pulse_receiver_if.sv
// evr_pulse_receiver_if: receive stream, channel configuration and trigger/time-stamp outputs
interface evr_pulse_receiver_if #(
    parameter int SECONDS_WIDTH = 32,
    parameter int TICKS_WIDTH   = 32,
    parameter int CHANNEL_COUNT = 4,
    parameter int DELAY_WIDTH   = 24,
    parameter int PWIDTH_WIDTH  = 16
);
    localparam int CW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
    localparam int TW = SECONDS_WIDTH + TICKS_WIDTH;
    logic [15:0]                 evrRxWord;
    logic [1:0]                  evrCharIsK;
    logic                        cfgWrite;
    logic [CW-1:0]               cfgChannel;
    logic                        cfgEnable;
    logic [7:0]                  cfgEvCode;
    logic [DELAY_WIDTH-1:0]      cfgDelay;
    logic [PWIDTH_WIDTH-1:0]     cfgWidth;
    logic [TW-1:0]               timestamp;
    logic                        timestampValid;
    logic                        ppsMarker;
    logic                        secondsError;
    logic [CHANNEL_COUNT-1:0]    pulseOut;
    logic [CHANNEL_COUNT-1:0]    trigValid;
    logic [CHANNEL_COUNT*TW-1:0] trigTimestamp;
    logic [7:0]                  distributedDataBus;
    modport master (
        output evrRxWord, evrCharIsK, cfgWrite, cfgChannel, cfgEnable, cfgEvCode, cfgDelay, cfgWidth,
        input  timestamp, timestampValid, ppsMarker, secondsError, pulseOut, trigValid, trigTimestamp,
               distributedDataBus
    );
    modport slave (
        input  evrRxWord, evrCharIsK, cfgWrite, cfgChannel, cfgEnable, cfgEvCode, cfgDelay, cfgWidth,
        output timestamp, timestampValid, ppsMarker, secondsError, pulseOut, trigValid, trigTimestamp,
               distributedDataBus
    );
endinterface

// File: rtl/evr_pulse_channel.sv
// evr_pulse_channel: one programmable delay/width pulse generator with trigger time-stamp latch
module evr_pulse_channel import evr_pkg::*; #(
    parameter int TW           = 64,
    parameter int DELAY_WIDTH  = 24,
    parameter int PWIDTH_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr_i,
    input  logic                    cfg_en_i,
    input  logic [7:0]              cfg_code_i,
    input  logic [DELAY_WIDTH-1:0]  cfg_delay_i,
    input  logic [PWIDTH_WIDTH-1:0] cfg_width_i,
    input  logic                    ev_valid_i,
    input  logic [7:0]              ev_code_i,
    input  logic [TW-1:0]           ev_ts_i,
    output logic                    pulse_o,
    output logic                    trig_valid_o,
    output logic [TW-1:0]           trig_ts_o
);
    localparam int NW = DELAY_WIDTH > PWIDTH_WIDTH ? DELAY_WIDTH : PWIDTH_WIDTH;
    ch_state_e               state_q, state_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic                    en_q;
    logic [7:0]              code_q;
    logic [DELAY_WIDTH-1:0]  delay_q;
    logic [PWIDTH_WIDTH-1:0] width_q;
    logic                    trig_q, trig_d;
    logic [TW-1:0]           ts_q, ts_d;
    logic                    hit;

    assign hit = ev_valid_i && en_q && ev_code_i == code_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        ts_d    = ts_q;
        if (cfg_wr_i) state_d = CH_IDLE;
        else case (state_q)
            CH_IDLE: if (hit) begin
                trig_d  = 1'b1;
                ts_d    = ev_ts_i;
                state_d = delay_q != '0 ? CH_DELAY : width_q != '0 ? CH_ACTIVE : CH_IDLE;
                cnt_d   = delay_q != '0 ? NW'(delay_q) : NW'(width_q);
            end
            CH_DELAY: begin
                // a zero width skips ACTIVE so the output never rises
                cnt_d   = cnt_q == NW'(1) ? NW'(width_q) : cnt_q - NW'(1);
                state_d = cnt_q != NW'(1) ? CH_DELAY : width_q != '0 ? CH_ACTIVE : CH_IDLE;
            end
            CH_ACTIVE: begin
                cnt_d   = cnt_q - NW'(1);
                state_d = cnt_q == NW'(1) ? CH_IDLE : CH_ACTIVE;
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            ts_q    <= '0;
            en_q    <= 1'b0;
            code_q  <= '0;
            delay_q <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            ts_q    <= ts_d;
            if (cfg_wr_i) begin
                en_q    <= cfg_en_i;
                code_q  <= cfg_code_i;
                delay_q <= cfg_delay_i;
                width_q <= cfg_width_i;
            end
        end

    assign pulse_o      = state_q == CH_ACTIVE;
    assign trig_valid_o = trig_q;
    assign trig_ts_o    = ts_q;
endmodule

// File: rtl/evr_pulse_receiver.sv
// evr_pulse_receiver: EVR stream decode, seconds/ticks time stamp and a bank of pulse generators
module evr_pulse_receiver import evr_pkg::*; #(
    parameter int SECONDS_WIDTH = 32,
    parameter int TICKS_WIDTH   = 32,
    parameter int CHANNEL_COUNT = 4,
    parameter int DELAY_WIDTH   = 24,
    parameter int PWIDTH_WIDTH  = 16,
    parameter int TICK_TIMEOUT  = 125000000 + 1000
) (
    input logic           evrRxClk,
    input logic           evrRxRst_n,
    evr_pulse_receiver_if.slave bus
);
    localparam int CW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
    localparam int TW = SECONDS_WIDTH + TICKS_WIDTH;
    localparam int BW = $clog2(SECONDS_WIDTH + 1);
    localparam logic [TICKS_WIDTH-1:0] TIMEOUT = TICKS_WIDTH'(TICK_TIMEOUT);

    logic [SECONDS_WIDTH-1:0] seconds_q, seconds_d, shift_q, shift_d, sec_inc;
    logic [TICKS_WIDTH-1:0]   ticks_q, ticks_d;
    logic [BW-1:0]            bits_left_q, bits_left_d;
    logic                     valid_q, valid_d, pps_q, err_q, err_d;
    logic                     pipe_valid_q;
    logic [7:0]               pipe_code_q;
    logic [TW-1:0]            pipe_ts_q;
    logic [7:0]               code;
    logic                     ev, is_marker, is_shift;

    assign code      = bus.evrRxWord[7:0];
    assign ev        = !bus.evrCharIsK[0];
    assign is_marker = ev && code == EV_SECONDS;
    assign is_shift  = ev && (code == EV_SHIFT0 || code == EV_SHIFT1);
    assign sec_inc   = seconds_q + SECONDS_WIDTH'(1);

    always_comb begin
        seconds_d   = seconds_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        ticks_d     = &ticks_q ? ticks_q : ticks_q + TICKS_WIDTH'(1);
        if (is_marker) begin
            // a complete shifted-in second is loaded, a short one just advances the count
            ticks_d     = '0;
            bits_left_d = BW'(SECONDS_WIDTH);
            seconds_d   = bits_left_q == '0 ? shift_q : sec_inc;
            valid_d     = bits_left_q == '0 ? 1'b1 : valid_q;
            err_d       = bits_left_q != '0 || (valid_q && shift_q != sec_inc);
        end else if (ticks_d == TIMEOUT) valid_d = 1'b0;
        if (is_shift) begin
            shift_d     = {shift_q[SECONDS_WIDTH-2:0], code[0]};
            bits_left_d = bits_left_q == '0 ? '0 : bits_left_q - BW'(1);
        end
    end

    always_ff @(posedge evrRxClk or negedge evrRxRst_n)
        if (!evrRxRst_n) begin
            seconds_q    <= '0;
            shift_q      <= '0;
            ticks_q      <= '0;
            bits_left_q  <= BW'(SECONDS_WIDTH);
            valid_q      <= 1'b0;
            pps_q        <= 1'b0;
            err_q        <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_code_q  <= '0;
            pipe_ts_q    <= '0;
        end else begin
            seconds_q    <= seconds_d;
            shift_q      <= shift_d;
            ticks_q      <= ticks_d;
            bits_left_q  <= bits_left_d;
            valid_q      <= valid_d;
            pps_q        <= is_marker;
            err_q        <= err_d;
            pipe_valid_q <= ev && code != '0;
            pipe_code_q  <= code;
            pipe_ts_q    <= {seconds_q, ticks_q};
        end

    assign bus.timestamp          = {seconds_q, ticks_q};
    assign bus.timestampValid     = valid_q;
    assign bus.ppsMarker          = pps_q;
    assign bus.secondsError       = err_q;
    assign bus.distributedDataBus = bus.evrRxWord[15:8];

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
        evr_pulse_channel #(
            .TW(TW),
            .DELAY_WIDTH(DELAY_WIDTH),
            .PWIDTH_WIDTH(PWIDTH_WIDTH)
        ) u_ch (
            .clk(evrRxClk),
            .rst_n(evrRxRst_n),
            .cfg_wr_i(bus.cfgWrite && bus.cfgChannel == CW'(c)),
            .cfg_en_i(bus.cfgEnable),
            .cfg_code_i(bus.cfgEvCode),
            .cfg_delay_i(bus.cfgDelay),
            .cfg_width_i(bus.cfgWidth),
            .ev_valid_i(pipe_valid_q),
            .ev_code_i(pipe_code_q),
            .ev_ts_i(pipe_ts_q),
            .pulse_o(bus.pulseOut[c]),
            .trig_valid_o(bus.trigValid[c]),
            .trig_ts_o(bus.trigTimestamp[c*TW +: TW])
        );
    end
endmodule

// File: doc/evr_pulse_receiver.md
# evr_pulse_receiver

Parametrised event receiver for the timing path: decodes the 16-bit EVR receive stream into a seconds/ticks time stamp and drives CHANNEL_COUNT programmable pulse generators. Each generator has its own event code, delay and width, and time-stamps its trigger. The block adds a seconds-consistency check and a missing-PPS watchdog. It sits directly behind the GT receive word on the recovered clock and feeds triggers and time stamps to acquisition and interlock logic.

## Interface
- SECONDS_WIDTH, 32: seconds field width (≥2).
- TICKS_WIDTH, 32: ticks field width (≥2).
- CHANNEL_COUNT, 4: number of pulse generators (≥1).
- DELAY_WIDTH, 24: delay counter width.
- PWIDTH_WIDTH, 16: pulse-width counter width.
- TICK_TIMEOUT, 125000000+1000: tick count at which the time stamp is declared stale; must be < 2^TICKS_WIDTH.
- CW = max(1, $clog2(CHANNEL_COUNT)); TW = SECONDS_WIDTH+TICKS_WIDTH (derived).

Ports:
- evrRxClk  in  1  recovered receive clock; the only clock.
- evrRxRst_n  in  1  asynchronous, active-low reset.
- evrRxWord  in  16  [7:0] event code, [15:8] distributed data.
- evrCharIsK  in  2  K-flags; event valid when evrCharIsK[0]==0.
- cfgWrite  in  1  one-cycle write strobe for channel configuration.
- cfgChannel  in  CW  channel addressed by cfgWrite.
- cfgEnable / cfgEvCode / cfgDelay / cfgWidth  in  1 / 8 / DELAY_WIDTH / PWIDTH_WIDTH  configuration values.
- timestamp  out  TW  {seconds, ticks}.
- timestampValid  out  1  time stamp trusted.
- ppsMarker  out  1  one-cycle strobe on event 0x7D.
- secondsError  out  1  one-cycle strobe on a seconds-protocol violation.
- pulseOut  out  CHANNEL_COUNT  generator outputs.
- trigValid  out  CHANNEL_COUNT  one-cycle strobe per accepted trigger.
- trigTimestamp  out  CHANNEL_COUNT*TW  per-channel latched time stamp; channel c is at [c*TW +: TW].
- distributedDataBus  out  8  evrRxWord[15:8], passed through combinationally.

## Operation
- Reset state: every output and all state clear to 0, all channels disabled and IDLE, bitsLeft = SECONDS_WIDTH.
- Event codes: 0x70 shifts in a 0, 0x71 shifts in a 1, 0x7D is the seconds marker; code 0x00 never triggers a channel.
- Each shift event moves the bit into shiftReg, MSB first, and decrements bitsLeft, saturating at 0.
- Marker with bitsLeft==0:
  - seconds ← shiftReg; ticks ← 0; timestampValid ← 1.
  - If timestampValid was already 1 and shiftReg ≠ seconds+1, pulse secondsError.
- Marker with bitsLeft≠0: seconds ← seconds+1 (wraps), ticks ← 0, secondsError pulses. timestampValid is left unchanged.
- After every marker, bitsLeft ← SECONDS_WIDTH.
- Ticks increment on every cycle with no marker and saturate at all-ones.
- When ticks reach TICK_TIMEOUT, timestampValid ← 0.
- Decode is registered: the code and a copy of timestamp are captured into a one-stage pipe.
- Channel FSM has three states: IDLE, DELAY, ACTIVE.
  - IDLE→: on a piped valid event matching an enabled channel's code, latch the piped timestamp into trigTimestamp and pulse trigValid. Go to ACTIVE if delay==0, otherwise DELAY with the counter loaded with delay.
  - DELAY: count down; enter ACTIVE when the count reaches 1.
  - ACTIVE: pulseOut=1 for exactly width cycles, then return to IDLE.
  - width==0: the trigger is still latched and strobed, pulseOut never rises, and the channel returns to IDLE.
- Matches arriving while a channel is in DELAY or ACTIVE are ignored: no re-latch, no trigValid.
- cfgWrite to a channel forces it to IDLE and drops pulseOut on the same edge; the new values apply from the next cycle.
- Multiple channels may match the same event and run independently.

## Timing
- The word sampled at edge N appears as ppsMarker at N+1. The timestamp update from that word is visible at N+1.
- trigValid and trigTimestamp are valid from N+2.
- trigTimestamp equals the timestamp value that was present during the cycle in which the triggering word was sampled.
- pulseOut rises at edge N+2+delay and stays high for width cycles.
- A marker and a shift event in the same word cannot occur; a single word carries one code.
- A shift event in the cycle immediately after a marker counts toward the next second.
- Asserting reset mid-pulse drops pulseOut asynchronously.

## Structure
- Package evr_pkg holds the event-code constants (0x70, 0x71, 0x7D) and the channel state enum.
- Sub-module evr_pulse_channel: one FSM, its counters and its trigger latch, instantiated CHANNEL_COUNT times by generate.
- The top level holds the decode pipe, the time-stamp logic and the configuration demux.

## Test plan
- Shift 32 bits encoding 0x12345678, then send marker 0x7D → timestamp = {0x12345678, 0}; timestampValid = 1; ppsMarker pulses once; no secondsError.
- Send the next second 0x12345679 correctly → no error. Then send a second with 0x12345690 → secondsError pulses once and seconds loads 0x12345690.
- Send a marker with only 5 shift bits → seconds increments by 1; secondsError pulses; bitsLeft is back to 32.
- Channel 0 configured with code 0x20, delay 3, width 4; event 0x20 sampled at edge N → trigValid at N+2; pulseOut high during N+5..N+8; trigTimestamp ticks equal the ticks value during cycle N.
- Repeat 0x20 during the DELAY state → ignored. Repeat with width=0 → trigValid pulses and no pulse is produced. cfgWrite mid-ACTIVE → pulseOut drops on the next edge.
- With TICK_TIMEOUT=100, send no marker → timestampValid clears when ticks reach 100. Assert reset mid-pulse → all outputs are 0 immediately.
